// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Control bundle between the multicycle controller and datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             adr_src;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       result_src;
  logic [3:0]       state_dbg;
  logic [CNT_W-1:0] instret;
  logic             illegal;

  // Controller side
  modport master (
    input  opcode, zero, mem_ready,
    output adr_src, mem_read, mem_write, ir_write, pc_write, reg_write,
    output alu_src_a, alu_src_b, alu_op, result_src,
    output state_dbg, instret, illegal
  );

  // Datapath side
  modport slave (
    output opcode, zero, mem_ready,
    input  adr_src, mem_read, mem_write, ir_write, pc_write, reg_write,
    input  alu_src_a, alu_src_b, alu_op, result_src,
    input  state_dbg, instret, illegal
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Moore FSM sequencing a multicycle RV32I-subset datapath, with
//               retired-instruction counter and sticky illegal-opcode flag.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  wire logic            clk,
  input  wire logic            reset,
  multicycle_ctrl_if.master    bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  logic [3:0]       state_q,   state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;

  logic             w_adr_src;
  logic             w_mem_read;
  logic             w_mem_write;
  logic             w_ir_write;
  logic             w_pc_update;
  logic             w_branch;
  logic             w_reg_write;
  logic [1:0]       w_alu_src_a;
  logic [1:0]       w_alu_src_b;
  logic [1:0]       w_alu_op;
  logic [1:0]       w_result_src;
  logic             w_retire;

  // State, counter and sticky flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR:   state_d = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase
  end

  // Counter and flag updates ride on the state transition just decided
  always_comb begin
    w_retire  = (state_d == S_FETCH) &&
                ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                 (state_q == S_ALUWB) || (state_q == S_BEQ));
    instret_d = w_retire ? instret_q + CNT_W'(1) : instret_q;
    illegal_d = illegal_q | (state_d == S_HALT);
  end

  // Output decode
  always_comb begin
    w_adr_src    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = SRCA_PC;
    w_alu_src_b  = SRCB_RS2;
    w_alu_op     = ALUOP_ADD;
    w_result_src = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        w_mem_read   = 1'b1;
        w_ir_write   = bus.mem_ready;
        w_pc_update  = bus.mem_ready;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALU;
      end
      S_DECODE: begin
        w_alu_src_a = SRCA_OLDPC;
        w_alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        w_alu_src_a = SRCA_RS1;
        w_alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        w_adr_src  = 1'b1;
        w_mem_read = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = RES_MEM;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        w_alu_src_a = SRCA_RS1;
        w_alu_src_b = SRCB_RS2;
        w_alu_op    = ALUOP_FUNC;
      end
      S_EXECI: begin
        w_alu_src_a = SRCA_RS1;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = ALUOP_FUNC;
      end
      S_ALUWB:  w_reg_write = 1'b1;
      S_JAL: begin
        w_alu_src_a = SRCA_OLDPC;
        w_alu_src_b = SRCB_FOUR;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        w_alu_src_a = SRCA_RS1;
        w_alu_src_b = SRCB_RS2;
        w_alu_op    = ALUOP_SUB;
        w_branch    = 1'b1;
      end
      default: ;
    endcase
    // Reset overrides the decoded state so nothing is strobed mid-reset
    if (reset) begin
      w_adr_src    = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_update  = 1'b0;
      w_branch     = 1'b0;
      w_reg_write  = 1'b0;
      w_alu_src_a  = 2'b00;
      w_alu_src_b  = 2'b00;
      w_alu_op     = 2'b00;
      w_result_src = 2'b00;
    end
  end

  assign bus.adr_src    = w_adr_src;
  assign bus.mem_read   = w_mem_read;
  assign bus.mem_write  = w_mem_write;
  assign bus.ir_write   = w_ir_write;
  assign bus.pc_write   = w_pc_update | (w_branch & bus.zero);
  assign bus.reg_write  = w_reg_write;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.result_src = w_result_src;
  assign bus.state_dbg  = state_q;
  assign bus.instret    = instret_q;
  assign bus.illegal    = illegal_q;

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM that sequences the multicycle RV32I-subset datapath: memory address source, IR/PC/register-file write strobes, ALU operand-select codes for the 3-input ALU-source muxes, ALU op class, and write-back result select.
- Sits beside the datapath.
- Consumes the instruction opcode, the ALU zero flag and a memory-ready handshake.
- Also keeps a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from the instruction register, valid from DECODE onward
- zero  in  1  ALU zero flag, used in BEQ state
- mem_ready  in  1  memory completes the current read/write this cycle
- adr_src  out  1  0 = PC, 1 = ALUOut as memory address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC = pc_update | (branch & zero)
- reg_write  out  1  register-file write enable
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 (A reg), 11 unused (mux yields 0)
- alu_src_b  out  2  00 rs2 (B reg), 01 immediate, 10 constant 4, 11 unused
- alu_op  out  2  00 add, 01 subtract (compare), 10 decode funct fields
- result_src  out  2  00 ALUOut, 01 memory data, 10 ALU result direct
- state_dbg  out  4  current state encoding
- instret  out  CNT_W  instructions retired since reset
- illegal  out  1  sticky: unsupported opcode decoded

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, HALT=11.
- Outputs are pure functions of state, except ir_write/pc_write in FETCH (gated by mem_ready) and pc_write in BEQ (gated by zero). Any output not listed for a state is 0.
- FETCH: adr_src=0, mem_read=1, a=00, b=10, alu_op=00, result_src=10. ir_write=pc_update=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: a=01, b=01, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other -> HALT
- MEMADR: a=10, b=01, alu_op=00. Goes to MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, mem_read=1, result_src=00. Waits for mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, then goes to FETCH.
- MEMWRITE: adr_src=1, mem_write=1, result_src=00. Waits for mem_ready, then goes to FETCH.
- EXECR: a=10, b=00, alu_op=10, then goes to ALUWB. EXECI: a=10, b=01, alu_op=10, then goes to ALUWB.
- ALUWB: result_src=00, reg_write=1, then goes to FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1 (PC takes the target held in ALUOut), then goes to ALUWB.
- BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1, then goes to FETCH. pc_write=zero.
- HALT: all strobes 0 and illegal=1. Only reset exits HALT.
- instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps modulo 2^CNT_W with no saturation.
- A memory wait of any length holds every output stable. mem_ready is ignored in states that are not memory states.
- Reset:
  - Registers: on a rising edge with reset=1, state<=FETCH, instret<=0 and illegal<=0, from any state, including mid-wait in MEMREAD/MEMWRITE.
  - Output gating: while reset=1, all strobes (mem_read, mem_write, ir_write, pc_write, reg_write) are forced to 0. alu_src_a/alu_src_b/alu_op/result_src are forced to 00.
  - First cycle after reset: FETCH outputs.
- Latency in cycles with zero-wait memory:
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - jal 4
  - beq 3

Test Plan:
- add x3,x1,x2 (opcode 0110011), mem_ready=1 -> state sequence 0,1,6,7,0. reg_write=1 only in ALUWB with result_src=00. instret goes 0->1.
- lw (0000011) with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles with adr_src=1 and mem_read=1 throughout. MEMWB shows result_src=01 and reg_write=1. Total 8 cycles.
- beq (1100011) with zero=1, then zero=0 -> pc_write=1 in BEQ for the first and 0 for the second. Both reach FETCH after 3 cycles and increment instret.
- jal (1101111) -> JAL has pc_write=1, a=01, b=10, then ALUWB has reg_write=1. instret increments.
- Opcode 1111111 -> HALT with illegal=1 and all strobes 0 for 20 cycles. reset=1 for one edge -> FETCH, illegal=0, instret=0.
- sw with reset asserted while in MEMWRITE waiting -> mem_write drops to 0 in the reset cycle. The next cycle is FETCH, with no reg_write and no instret increment.
